// File: rtl/fsb_loopback_node.sv
// FSB loopback endpoint: echo, rx/err counter readback, clear; optional stall counter (FSB_LOOPBACK_STALL_COUNT_EN).
// Latency: accept in cycle t into an idle node gives fsb_v_o in cycle t+2 (FIFO write, then pop into output flop).
// Backpressure: fsb_ready_o drops while the input FIFO is full; the output flop holds until fsb_yumi_i.

// Generic synchronous FIFO: pointer-based, one extra wrap bit to tell full from empty.
// Latency: a pushed entry appears at head_dat the cycle after the push.
// Backpressure: caller must not push while full nor pop while empty.
module fsb_loopback_fifo #(
  parameter int width_p = 80,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               push,
  input  logic [width_p-1:0] push_dat,
  input  logic               pop,
  output logic [width_p-1:0] head_dat,
  output logic               empty,
  output logic               full
);

  localparam int aw_lp = $clog2(els_p);
  localparam logic [aw_lp:0] ptr_one_lp = (aw_lp + 1)'(1);

  logic [aw_lp:0]       wr_ptr;
  logic [aw_lp:0]       rd_ptr;
  logic [width_p-1:0]   mem [els_p];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[aw_lp] != rd_ptr[aw_lp]) &&
                    (wr_ptr[aw_lp-1:0] == rd_ptr[aw_lp-1:0]);
  assign head_dat = mem[rd_ptr[aw_lp-1:0]];

  // Pointer advance; reset empties the FIFO regardless of stored data.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one_lp;
      if (pop)  rd_ptr <= rd_ptr + ptr_one_lp;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[aw_lp-1:0]] <= push_dat;
  end

endmodule

// FSB loopback node top: input FIFO, opcode dispatch, single registered response stage.
// Latency: 2 cycles accept-to-response when idle; one response per cycle with fsb_yumi_i held high.
// Backpressure: fsb_ready_o = not full (and out of reset); a stalled response blocks further pops.
module fsb_loopback_node #(
  parameter int fsb_width_p   = 80,
  parameter int els_p         = 4,
  parameter int count_width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     fsb_v_i,
  input  logic [fsb_width_p-1:0]   fsb_data_i,
  output logic                     fsb_ready_o,
  output logic                     fsb_v_o,
  output logic [fsb_width_p-1:0]   fsb_data_o,
  input  logic                     fsb_yumi_i,
  output logic [count_width_p-1:0] rx_count_o,
  output logic [count_width_p-1:0] err_count_o
);

  localparam logic [3:0] op_echo_lp     = 4'h0;
  localparam logic [3:0] op_read_rx_lp  = 4'h1;
  localparam logic [3:0] op_clear_lp    = 4'h2;
  localparam logic [3:0] op_read_err_lp = 4'h3;
`ifdef FSB_LOOPBACK_STALL_COUNT_EN
  localparam logic [3:0] op_read_stall_lp = 4'h4;
`endif
  localparam logic [count_width_p-1:0] cnt_one_lp = count_width_p'(1);

  logic                     up_q;
  logic                     accept;
  logic                     consume;
  logic                     pop;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [fsb_width_p-1:0]   head_dat;
  logic [3:0]               op;
  logic                     resp_load;
  logic [fsb_width_p-1:0]   resp_dat;
  logic                     clear;
  logic                     unknown;
  logic                     out_v_q;
  logic [fsb_width_p-1:0]   out_dat_q;
  logic [count_width_p-1:0] rx_q;
  logic [count_width_p-1:0] err_q;
`ifdef FSB_LOOPBACK_STALL_COUNT_EN
  logic [count_width_p-1:0] stall_q;
`endif

  // ready is held low in reset and for the edge that releases it
  assign fsb_ready_o = up_q & ~fifo_full;
  assign accept      = fsb_v_i & fsb_ready_o;
  assign consume     = out_v_q & fsb_yumi_i;
  assign pop         = ~fifo_empty & (~out_v_q | consume);
  assign op          = head_dat[fsb_width_p-1 -: 4];

  fsb_loopback_fifo #(
    .width_p (fsb_width_p),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .push     (accept),
    .push_dat (fsb_data_i),
    .pop      (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Marks the first edge after reset release so ready rises there.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) up_q <= 1'b0;
    else           up_q <= 1'b1;
  end

  // Opcode decode of the popped head; counters read here are pre-update values.
  always_comb begin
    resp_load = 1'b0;
    resp_dat  = '0;
    clear     = 1'b0;
    unknown   = 1'b0;
    if (pop) begin
      case (op)
        op_echo_lp: begin
          resp_load = 1'b1;
          resp_dat  = head_dat;
        end
        op_read_rx_lp: begin
          resp_load = 1'b1;
          resp_dat[fsb_width_p-1 -: 4]  = op;
          resp_dat[count_width_p-1:0]   = rx_q;
        end
        op_clear_lp: begin
          clear = 1'b1;
        end
        op_read_err_lp: begin
          resp_load = 1'b1;
          resp_dat[fsb_width_p-1 -: 4]  = op;
          resp_dat[count_width_p-1:0]   = err_q;
        end
`ifdef FSB_LOOPBACK_STALL_COUNT_EN
        op_read_stall_lp: begin
          resp_load = 1'b1;
          resp_dat[fsb_width_p-1 -: 4]  = op;
          resp_dat[count_width_p-1:0]   = stall_q;
        end
`endif
        default: begin
          unknown = 1'b1;
        end
      endcase
    end
  end

  // Output stage: load a new response, else drop valid once consumed.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      out_v_q   <= 1'b0;
      out_dat_q <= '0;
    end else if (resp_load) begin
      out_v_q   <= 1'b1;
      out_dat_q <= resp_dat;
    end else if (consume) begin
      out_v_q   <= 1'b0;
    end
  end

  // rx counter: CLEAR wins, but a same-cycle accept still counts as the first packet.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)   rx_q <= '0;
    else if (clear)  rx_q <= accept ? cnt_one_lp : '0;
    else if (accept) rx_q <= rx_q + cnt_one_lp;
  end

  // err counter: dropped unknown opcodes.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)    err_q <= '0;
    else if (clear)   err_q <= '0;
    else if (unknown) err_q <= err_q + cnt_one_lp;
  end

`ifdef FSB_LOOPBACK_STALL_COUNT_EN
  // stall counter: cycles a response sits unconsumed (never coincides with a pop).
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)                    stall_q <= '0;
    else if (clear)                   stall_q <= '0;
    else if (out_v_q && !fsb_yumi_i)  stall_q <= stall_q + cnt_one_lp;
  end
`endif

  assign fsb_v_o     = out_v_q;
  assign fsb_data_o  = out_dat_q;
  assign rx_count_o  = rx_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_fsb_loopback_node.sv
// Bench for fsb_loopback_node: directed scenarios plus random traffic against a queue-based model.
// The model tracks accepted packets, the pending response and counters per clock edge.
// Macro FSB_LOOPBACK_STALL_COUNT_EN enables the READ_STALL scenario and model.
module tb_fsb_loopback_node;

  localparam int W   = 80;
  localparam int ELS = 4;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          fsb_v_i;
  logic [W-1:0]  fsb_data_i;
  logic          fsb_ready_o;
  logic          fsb_v_o;
  logic [W-1:0]  fsb_data_o;
  logic          fsb_yumi_i;
  logic [CW-1:0] rx_count_o;
  logic [CW-1:0] err_count_o;

  int checks   = 0;
  int failures = 0;

  // driver state
  logic [W-1:0] pending[$];
  logic [W-1:0] obs[$];
  bit           gate;
  bit           want_yumi;

  // reference model state
  logic [W-1:0]  m_fifo[$];
  logic [W-1:0]  m_out;
  bit            m_out_v;
  bit            m_up;
  logic [CW-1:0] m_rx;
  logic [CW-1:0] m_err;
  logic [CW-1:0] m_stall;

  always #5 clk = ~clk;

  fsb_loopback_node #(.fsb_width_p(W), .els_p(ELS), .count_width_p(CW)) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .fsb_v_i     (fsb_v_i),
    .fsb_data_i  (fsb_data_i),
    .fsb_ready_o (fsb_ready_o),
    .fsb_v_o     (fsb_v_o),
    .fsb_data_o  (fsb_data_o),
    .fsb_yumi_i  (fsb_yumi_i),
    .rx_count_o  (rx_count_o),
    .err_count_o (err_count_o)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [3:0] op, input logic [CW-1:0] val);
    logic [W-1:0] r;
    r = '0;
    r[W-1 -: 4] = op;
    r[CW-1:0]   = val;
    return r;
  endfunction

  function automatic logic [W-1:0] pkt(input logic [3:0] op, input logic [W-5:0] body);
    return {op, body};
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    m_out   = '0;
    m_out_v = 0;
    m_up    = 0;
    m_rx    = '0;
    m_err   = '0;
    m_stall = '0;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare after the edge.
  task automatic step();
    bit acc, pop, cons, clr, unk, stall_inc;
    logic [W-1:0] h;
    fsb_v_i    = gate && (pending.size() > 0);
    fsb_data_i = fsb_v_i ? pending[0] : W'({$urandom, $urandom, $urandom});
    fsb_yumi_i = want_yumi && m_out_v;
    acc        = fsb_v_i && m_up && (m_fifo.size() < ELS);
    pop        = (m_fifo.size() > 0) && (!m_out_v || fsb_yumi_i);
    cons       = m_out_v && fsb_yumi_i;
    stall_inc  = m_out_v && !fsb_yumi_i;
    if (cons) obs.push_back(fsb_data_o);
    @(posedge clk);
    #1;
    clr = 0;
    unk = 0;
    if (cons) m_out_v = 0;
    if (pop) begin
      h = m_fifo.pop_front();
      case (h[W-1 -: 4])
        4'h0: begin m_out = h;               m_out_v = 1; end
        4'h1: begin m_out = mk(4'h1, m_rx);  m_out_v = 1; end
        4'h2: clr = 1;
        4'h3: begin m_out = mk(4'h3, m_err); m_out_v = 1; end
`ifdef FSB_LOOPBACK_STALL_COUNT_EN
        4'h4: begin m_out = mk(4'h4, m_stall); m_out_v = 1; end
`endif
        default: unk = 1;
      endcase
    end
    if (acc) m_fifo.push_back(pending.pop_front());
    m_rx    = clr ? CW'(acc) : m_rx + CW'(acc);
    m_err   = clr ? '0 : m_err + CW'(unk);
    m_stall = clr ? '0 : m_stall + CW'(stall_inc);
    m_up    = 1;
    check("v_o", W'(fsb_v_o), W'(m_out_v));
    if (m_out_v) check("data_o", fsb_data_o, m_out);
    check("ready", W'(fsb_ready_o), W'(m_up && (m_fifo.size() < ELS)));
    check("rx", W'(rx_count_o), W'(m_rx));
    check("err", W'(err_count_o), W'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #3;
    resetn     = 1'b0;
    fsb_v_i    = 1'b0;
    fsb_yumi_i = 1'b0;
    #1;
    check("rst_v_o", W'(fsb_v_o), '0);
    check("rst_data_o", fsb_data_o, '0);
    check("rst_ready", W'(fsb_ready_o), '0);
    check("rst_rx", W'(rx_count_o), '0);
    check("rst_err", W'(err_count_o), '0);
    model_clear();
    pending.delete();
    obs.delete();
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    #1;
    check("ready_before_edge", W'(fsb_ready_o), '0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] e;
    resetn     = 1'b0;
    fsb_v_i    = 1'b0;
    fsb_data_i = '0;
    fsb_yumi_i = 1'b0;
    gate       = 1;
    want_yumi  = 0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Echo into an idle node: response two cycles after accept.
    want_yumi = 1;
    pending.push_back(80'h0_0000_0000_DEAD_BEEF);
    step();
    check("echo_t1_v", W'(fsb_v_o), '0);
    step();
    check("echo_t2_v", W'(fsb_v_o), W'(1));
    check("echo_t2_dat", fsb_data_o, 80'h0_0000_0000_DEAD_BEEF);
    check("echo_rx", W'(rx_count_o), W'(1));
    run(3);

    // Full: 4 in FIFO + 1 in output stage, sixth held until consumption resumes.
    do_reset();
    want_yumi = 0;
    for (int i = 0; i < 6; i++) pending.push_back(pkt(4'h0, 76'(i + 16)));
    run(10);
    check("full_ready", W'(fsb_ready_o), '0);
    check("full_rx", W'(rx_count_o), W'(5));
    want_yumi = 1;
    run(12);
    check("full_nresp", W'(obs.size()), W'(6));
    for (int i = 0; i < 6 && i < obs.size(); i++)
      check("full_order", obs[i], pkt(4'h0, 76'(i + 16)));

    // Readback: READ_RX counts itself since it is accepted before it pops.
    do_reset();
    want_yumi = 1;
    for (int i = 0; i < 3; i++) pending.push_back(pkt(4'h0, 76'(i + 100)));
    pending.push_back(pkt(4'h1, '0));
    run(12);
    check("rd_nresp", W'(obs.size()), W'(4));
    e = mk(4'h1, 32'd4);
    if (obs.size() == 4) check("rd_rx_payload", obs[3], e);

    // Unknown opcodes are dropped and counted.
    do_reset();
    want_yumi = 1;
    pending.push_back(pkt(4'h7, 76'h123));
    pending.push_back(pkt(4'hF, 76'h456));
    run(8);
    check("err_cnt", W'(err_count_o), W'(2));
    check("err_nresp", W'(obs.size()), '0);
    // CLEAR pops in the cycle READ_ERR is accepted, so rx restarts at 1.
    pending.push_back(pkt(4'h2, '0));
    pending.push_back(pkt(4'h3, '0));
    run(8);
    check("clr_nresp", W'(obs.size()), W'(1));
    e = mk(4'h3, 32'd0);
    if (obs.size() == 1) check("clr_err_payload", obs[0], e);
    check("clr_rx", W'(rx_count_o), W'(1));

    // Reset with a held response and a partly filled FIFO: nothing stale afterwards.
    do_reset();
    want_yumi = 0;
    for (int i = 0; i < 4; i++) pending.push_back(pkt(4'h0, 76'(i + 200)));
    run(8);
    check("pre_rst_v", W'(fsb_v_o), W'(1));
    do_reset();
    want_yumi = 1;
    run(10);
    check("no_stale", W'(obs.size()), '0);

`ifdef FSB_LOOPBACK_STALL_COUNT_EN
    // Ten stalled cycles with a pending response, then READ_STALL.
    do_reset();
    want_yumi = 0;
    pending.push_back(pkt(4'h0, 76'h77));
    for (int i = 0; i < 10 && !m_out_v; i++) step();
    run(10);
    want_yumi = 1;
    pending.push_back(pkt(4'h4, '0));
    run(6);
    check("stall_nresp", W'(obs.size()), W'(2));
    e = mk(4'h4, 32'd10);
    if (obs.size() == 2) check("stall_payload", obs[1], e);
`endif

    // Random traffic: mixed opcodes, valid gaps and random consumption.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (pending.size() < 3) begin
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2, 3: op = 4'h0;
          4:          op = 4'h1;
          5:          op = 4'h2;
          6:          op = 4'h3;
          7:          op = 4'h4;
          default:    op = 4'($urandom);
        endcase
        pending.push_back(pkt(op, 76'({$urandom, $urandom, $urandom})));
      end
      gate      = ($urandom_range(0, 3) != 0);
      want_yumi = ($urandom_range(0, 2) != 0);
      step();
    end
    gate = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
